// File: rtl/uart_rx_core_if.sv
// Received-byte stream between the UART receiver and its consumer.
// The byte is taken on any cycle where rx_valid and rx_ready are both high.
interface uart_rx_core_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver with a one-byte holding register; rx_valid rises 3+HALF_BIT+9*CLKS_PER_BIT+1 cycles after the start edge.
// The consumer stalls with rx_ready low; a byte arriving while the held byte is unconsumed is dropped and flags overrun.
module uart_rx_core #(
  parameter int CLKS_PER_BIT = 868,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic          Clk,
  input  logic          reset_ah,
  input  logic          rxd,
  input  logic          clr_err,
  output logic          overrun,
  output logic          frame_err,
  output logic          busy,
  uart_rx_core_if.master rx
);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(HALF_BIT - 1);

  state_t      state, state_nxt;
  logic        rxd_m, rxd_s;
  logic [15:0] cnt, cnt_nxt;
  logic [3:0]  bit_idx, bit_idx_nxt;
  logic [7:0]  shreg, shreg_nxt;
  logic        stop_ok, stop_bad;
  logic        dlv_q, ferr_q;

  always_ff @(posedge Clk) begin
    if (reset_ah) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
    end
  end

  always_ff @(posedge Clk) begin
    if (reset_ah) begin
      state   <= IDLE;
      cnt     <= 16'd0;
      bit_idx <= 4'd0;
      shreg   <= 8'h00;
      dlv_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_idx_nxt;
      shreg   <= shreg_nxt;
      dlv_q   <= stop_ok;
      ferr_q  <= stop_bad;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt + 16'd1;
    bit_idx_nxt = bit_idx;
    shreg_nxt   = shreg;
    stop_ok     = 1'b0;
    stop_bad    = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = 16'd0;
        if (!rxd_s) state_nxt = START;
      end
      START: begin
        // Line back high at mid start bit means a glitch, not a frame.
        if (cnt == HALF_LAST) begin
          cnt_nxt     = 16'd0;
          bit_idx_nxt = 4'd0;
          state_nxt   = rxd_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt     = 16'd0;
          shreg_nxt   = {rxd_s, shreg[7:1]};
          bit_idx_nxt = bit_idx + 4'd1;
          if (bit_idx == 4'd7) state_nxt = STOP;
        end
      end
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt = 16'd0;
          if (rxd_s) begin
            stop_ok   = 1'b1;
            state_nxt = IDLE;
          end else begin
            stop_bad  = 1'b1;
            state_nxt = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        cnt_nxt = 16'd0;
        if (rxd_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Delivery happens the cycle after the stop sample; shreg is untouched in IDLE.
  always_ff @(posedge Clk) begin
    if (reset_ah) begin
      rx.rx_data  <= 8'h00;
      rx.rx_valid <= 1'b0;
      overrun     <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      if (dlv_q && (!rx.rx_valid || rx.rx_ready)) begin
        rx.rx_data  <= shreg;
        rx.rx_valid <= 1'b1;
      end else if (rx.rx_valid && rx.rx_ready) begin
        rx.rx_valid <= 1'b0;
      end
      overrun   <= (dlv_q && rx.rx_valid && !rx.rx_ready) || (overrun && !clr_err);
      frame_err <= ferr_q || (frame_err && !clr_err);
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Randomized bench for uart_rx_core: frames are scheduled against a timing/delivery model
// and DUT outputs are compared with it every cycle, plus directed literal checks.
module tb_uart_rx_core;
  localparam int C   = 16;
  localparam int H   = C / 2;
  localparam int LAT = 3 + H + 9 * C + 1;

  logic Clk;
  logic reset_ah;
  logic rxd;
  logic clr_err;
  logic overrun;
  logic frame_err;
  logic busy;

  uart_rx_core_if rx_if ();

  uart_rx_core #(.CLKS_PER_BIT(C), .HALF_BIT(H)) dut (
    .Clk       (Clk),
    .reset_ah  (reset_ah),
    .rxd       (rxd),
    .clr_err   (clr_err),
    .overrun   (overrun),
    .frame_err (frame_err),
    .busy      (busy),
    .rx        (rx_if)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit chk_on   = 1'b0;
  bit rnd_on   = 1'b0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: each frame produces one event LAT cycles after its start edge.
  typedef struct {
    int         at;
    bit         good;
    logic [7:0] b;
  } ev_t;
  ev_t evq[$];

  logic [7:0] m_data;
  logic       m_valid, m_ovr, m_ferr;
  int         now;
  bit         dl, fe;
  logic [7:0] db;

  always @(posedge Clk) begin
    now = cyc + 1;
    dl  = 1'b0;
    fe  = 1'b0;
    db  = 8'h00;
    if (reset_ah) begin
      m_data  <= 8'h00;
      m_valid <= 1'b0;
      m_ovr   <= 1'b0;
      m_ferr  <= 1'b0;
      evq.delete();
    end else begin
      if (evq.size() > 0 && evq[0].at == now) begin
        dl = evq[0].good;
        fe = !evq[0].good;
        db = evq[0].b;
        void'(evq.pop_front());
      end
      if (dl && (!m_valid || rx_if.rx_ready)) begin
        m_data  <= db;
        m_valid <= 1'b1;
      end else if (m_valid && rx_if.rx_ready) begin
        m_valid <= 1'b0;
      end
      m_ovr  <= (dl && m_valid && !rx_if.rx_ready) || (m_ovr && !clr_err);
      m_ferr <= fe || (m_ferr && !clr_err);
    end
  end

  always @(negedge Clk) begin
    if (chk_on) begin
      chk("cyc_rx_valid", 32'(rx_if.rx_valid), 32'(m_valid));
      chk("cyc_overrun", 32'(overrun), 32'(m_ovr));
      chk("cyc_frame_err", 32'(frame_err), 32'(m_ferr));
      if (m_valid) chk("cyc_rx_data", 32'(rx_if.rx_data), 32'(m_data));
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  int last_start;

  // Called just after a clock edge; leaves the line at the stop value.
  task automatic send_frame(input logic [7:0] b, input bit stop);
    ev_t e;
    rxd        = 1'b0;
    last_start = cyc;
    e.at   = cyc + LAT;
    e.good = stop;
    e.b    = b;
    evq.push_back(e);
    repeat (C) tick();
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (C) tick();
    end
    rxd = stop;
    repeat (C) tick();
  endtask

  int         g_lat;
  logic [7:0] g_got;
  logic       g_after;

  task automatic send_and_catch(input logic [7:0] b);
    fork
      send_frame(b, 1'b1);
      begin
        g_lat   = -1;
        g_got   = 8'h00;
        g_after = 1'b1;
        for (int i = 0; i < 400 && g_lat < 0; i++) begin
          tick();
          if (rx_if.rx_valid) begin
            g_lat = cyc - last_start;
            g_got = rx_if.rx_data;
          end
        end
        tick();
        g_after = rx_if.rx_valid;
      end
    join
  endtask

  initial begin
    rxd             = 1'b1;
    reset_ah        = 1'b1;
    clr_err         = 1'b0;
    rx_if.rx_ready  = 1'b0;
    repeat (3) tick();
    reset_ah = 1'b0;
    chk_on   = 1'b1;
    chk("rst_rx_data", 32'(rx_if.rx_data), 32'h00);
    chk("rst_rx_valid", 32'(rx_if.rx_valid), 32'h0);
    chk("rst_overrun", 32'(overrun), 32'h0);
    chk("rst_frame_err", 32'(frame_err), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);

    // Single byte latency and one-cycle valid
    rx_if.rx_ready = 1'b1;
    tick();
    send_and_catch(8'h5A);
    chk("single_lat", 32'(g_lat), 32'd156);
    chk("single_data", 32'(g_got), 32'h5A);
    chk("single_one_cycle", 32'(g_after), 32'h0);
    chk("single_flags", 32'({overrun, frame_err}), 32'h0);

    // Glitch rejection
    rxd = 1'b0;
    repeat (4) tick();
    rxd = 1'b1;
    chk("glitch_busy_hi", 32'(busy), 32'h1);
    repeat (12) tick();
    chk("glitch_busy_lo", 32'(busy), 32'h0);
    chk("glitch_no_valid", 32'(rx_if.rx_valid), 32'h0);
    chk("glitch_flags", 32'({overrun, frame_err}), 32'h0);
    send_and_catch(8'hA5);
    chk("glitch_next_data", 32'(g_got), 32'hA5);
    chk("glitch_next_lat", 32'(g_lat), 32'd156);

    // Overrun
    rx_if.rx_ready = 1'b0;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    chk("ovr_data", 32'(rx_if.rx_data), 32'h11);
    chk("ovr_valid", 32'(rx_if.rx_valid), 32'h1);
    chk("ovr_flag", 32'(overrun), 32'h1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("ovr_cleared", 32'(overrun), 32'h0);

    // Same-cycle accept with 0x11 still held
    fork
      send_frame(8'h22, 1'b1);
      begin
        repeat (LAT - 1) tick();
        rx_if.rx_ready = 1'b1;
        tick();
        rx_if.rx_ready = 1'b0;
        chk("same_data", 32'(rx_if.rx_data), 32'h22);
        chk("same_valid", 32'(rx_if.rx_valid), 32'h1);
        chk("same_overrun", 32'(overrun), 32'h0);
      end
    join
    rx_if.rx_ready = 1'b1;
    tick();

    // Framing error and break hold
    send_frame(8'h3C, 1'b0);
    repeat (40) tick();
    chk("ferr_flag", 32'(frame_err), 32'h1);
    chk("ferr_no_valid", 32'(rx_if.rx_valid), 32'h0);
    chk("ferr_wait_busy", 32'(busy), 32'h1);
    rxd = 1'b1;
    repeat (5) tick();
    chk("ferr_idle", 32'(busy), 32'h0);
    send_and_catch(8'hC3);
    chk("ferr_next_data", 32'(g_got), 32'hC3);
    chk("ferr_sticky", 32'(frame_err), 32'h1);

    // Mid-frame reset during data bit 4
    fork
      send_frame(8'hFF, 1'b1);
      begin
        repeat (88) tick();
        reset_ah = 1'b1;
        tick();
        reset_ah = 1'b0;
        chk("mrst_rx_data", 32'(rx_if.rx_data), 32'h00);
        chk("mrst_rx_valid", 32'(rx_if.rx_valid), 32'h0);
        chk("mrst_flags", 32'({overrun, frame_err}), 32'h0);
        chk("mrst_busy", 32'(busy), 32'h0);
      end
    join
    repeat (20) tick();
    send_and_catch(8'h81);
    chk("mrst_next_data", 32'(g_got), 32'h81);
    chk("mrst_next_lat", 32'(g_lat), 32'd156);

    // Randomized traffic: frames, glitches, bad stops, random ready/clear
    rnd_on = 1'b1;
    fork
      begin
        for (int n = 0; n < 40; n++) begin
          int kind;
          kind = int'($urandom_range(0, 9));
          if (kind == 0) begin
            rxd = 1'b0;
            repeat (int'($urandom_range(1, 6))) tick();
            rxd = 1'b1;
            repeat (H + 6) tick();
          end else if (kind == 1) begin
            send_frame(8'($urandom_range(0, 255)), 1'b0);
            repeat (int'($urandom_range(0, 30))) tick();
            rxd = 1'b1;
            repeat (5) tick();
          end else begin
            send_frame(8'($urandom_range(0, 255)), 1'b1);
            if ($urandom_range(0, 3) != 0) repeat (int'($urandom_range(1, 20))) tick();
          end
        end
        rnd_on = 1'b0;
      end
      begin
        while (rnd_on) begin
          rx_if.rx_ready = ($urandom_range(0, 3) != 0);
          clr_err        = ($urandom_range(0, 15) == 0);
          tick();
        end
      end
    join
    rx_if.rx_ready = 1'b1;
    clr_err        = 1'b0;
    rxd            = 1'b1;
    repeat (200) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Synthesizable 8N1 UART receiver that recovers bytes from the serial `rxd` line and presents them on a valid/ready byte interface. It is the receive-side counterpart to the UART transmit path, letting fabric logic such as a command decoder feeding the HDMI text controller take serial input without the soft processor. It includes an input synchronizer, start-bit glitch rejection, a mid-bit sampling state machine, a one-byte holding register, and sticky error flags.

## Interface
- `CLKS_PER_BIT`, default 868, is the `Clk` cycles per bit (100 MHz / 115200). Legal range is 4 to 65535; a 16-bit counter is used.
- `HALF_BIT`, default `CLKS_PER_BIT/2` (integer division), is the cycle offset from the start-bit edge to the start-bit sample.
- `Clk` is an input, 1 bit: the system clock, rising edge.
- `reset_ah` is an input, 1 bit: synchronous, active-high reset.
- `rxd` is an input, 1 bit: asynchronous serial line, idle high.
- `rx_data` is an output, 8 bits: the held received byte.
- `rx_valid` is an output, 1 bit: `rx_data` holds an unconsumed byte.
- `rx_ready` is an input, 1 bit: the consumer accepts the byte when `rx_valid && rx_ready`.
- `clr_err` is an input, 1 bit: clears `overrun` and `frame_err`.
- `overrun` is an output, 1 bit: sticky; set when a byte is dropped.
- `frame_err` is an output, 1 bit: sticky; set when a stop bit is sampled low.
- `busy` is an output, 1 bit: high whenever the FSM is not in IDLE.

## Operation
- **Synchronizer:** `rxd` passes through two flops to produce `rxd_s`. Both flops reset to 1.
- **IDLE:**
  - When `rxd_s==0`, load `cnt=0` and go to START.
- **START:**
  - `cnt` increments each cycle.
  - At `cnt==HALF_BIT-1`, sample `rxd_s`. A 1 is a glitch: return to IDLE with no flags. A 0 loads `cnt=0`, `bit_idx=0` and goes to DATA.
- **DATA:**
  - At `cnt==CLKS_PER_BIT-1`, shift `rxd_s` into `shreg` LSB-first, set `cnt=0`, and increment `bit_idx`.
  - After the 8th sample (`bit_idx` reaches 8), go to STOP.
- **STOP:**
  - At `cnt==CLKS_PER_BIT-1`, sample `rxd_s`.
  - If 1: deliver `shreg` (see below) and go to IDLE.
  - If 0: set `frame_err`, discard the byte, and go to WAIT_IDLE.
- **WAIT_IDLE:**
  - Stay until `rxd_s==1`, then go to IDLE.
  - This prevents a break condition from re-triggering reception.
- **Delivery:**
  - If `rx_valid==0`, or `rx_ready==1` in the same cycle: `rx_data<=shreg` and `rx_valid<=1`.
  - Otherwise: `rx_data` is unchanged, the new byte is dropped, and `overrun<=1`.
- **Handshake:**
  - `rx_valid` clears on the cycle after `rx_valid && rx_ready`, unless a delivery occurs in that same cycle.
  - `rx_data` is stable while `rx_valid` is high.
- **Errors:**
  - `clr_err` clears both sticky flags.
  - If `clr_err` coincides with a set event, the set wins.
- **Reset:**
  - Applies in any state.
  - `cnt`, `bit_idx` and `shreg` go to 0; the FSM goes to IDLE; a frame in progress is abandoned.
  - After reset, the first falling edge seen on `rxd_s` starts a new frame. A line held low through reset is treated as a start.

## Timing
- **Reset values:**
  - `rx_data`=8'h00, `rx_valid`=0, `overrun`=0, `frame_err`=0, `busy`=0.
  - The synchronizer flops reset to 1.
- **Start detect:** `rxd` falling to START entry takes 3 `Clk` cycles (2 synchronizer stages plus the IDLE decision).
- **Sampling:** the start bit is sampled `HALF_BIT` cycles after START entry. Each following sample is `CLKS_PER_BIT` cycles after the previous one.
- **Valid latency:** `rx_valid` rises on the cycle after the stop-bit sample.
  - From the start edge on `rxd`, that is 3 + `HALF_BIT` + 9·`CLKS_PER_BIT` + 1 cycles.
  - With `CLKS_PER_BIT=16` this is 156 cycles.
- **frame_err timing:** `frame_err` rises on the same cycle that `rx_valid` would have risen.
- **Back-to-back frames:** supported. IDLE is re-entered mid-stop-bit, so the next start edge can be detected anywhere from half a bit onward.
- **Throughput:** one byte per 10 bit times.
- **busy:** combinational from the FSM state register.

## Test plan
- **Single byte:** with `CLKS_PER_BIT=16`, `rx_ready=1`, reset, then drive 0x5A in 8N1. Expect `rx_data=8'h5A`, `rx_valid` high for exactly 1 cycle at 156 cycles after the start edge, and `frame_err=overrun=0`.
- **Glitch rejection:** pulse `rxd` low for 4 cycles (less than `HALF_BIT`). Expect a return to IDLE, no `rx_valid`, no flags, and `busy` back to 0 within 12 cycles. Then send 0xA5; expect it received correctly.
- **Overrun:** hold `rx_ready=0` and send 0x11 then 0x22 back-to-back. Expect `rx_data=8'h11` with `rx_valid` high and `overrun=1` after the second stop bit. Pulse `clr_err` and expect `overrun=0`.
- **Same-cycle accept:** with 0x11 held, assert `rx_ready` in exactly the cycle 0x22 is delivered. Expect `rx_data=8'h22`, `rx_valid` remaining 1, and `overrun=0`.
- **Framing error:** send 0x3C with the stop bit driven 0, then hold the line low 40 cycles. Expect `frame_err=1`, no `rx_valid`, and the FSM in WAIT_IDLE. Release high, send 0xC3, and expect correct reception with `frame_err` still 1.
- **Mid-frame reset:** assert `reset_ah` for 1 cycle during data bit 4 of 0xFF. Expect all outputs at reset values and no byte delivered. The next frame, 0x81, is received correctly.
